// File: rtl/bitwise_result_checker.sv
// Scoreboard for the staged bitwise-op producer: latches an operand pair, checks the
// OR, AND and XOR result stages in order and reports a registered per-transaction verdict.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | op_ready high, waiting for an operand pair
// S_WAIT_OR  | expecting a|b on res_data
// S_WAIT_AND | expecting a&b on res_data
// S_WAIT_XOR | expecting a^b on res_data
// S_REPORT   | done pulse; verdict outputs already hold this transaction
module bitwise_result_checker #(
  parameter int WIDTH     = 8,
  parameter int TIMEOUT   = 15,
  parameter int TIMEOUT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_data,
  output logic             done,
  output logic             pass,
  output logic [2:0]       err_mask,
  output logic             timeout,
  output logic [7:0]       err_count,
  output logic             stray
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_OR  = 3'd1;
  localparam logic [2:0] S_WAIT_AND = 3'd2;
  localparam logic [2:0] S_WAIT_XOR = 3'd3;
  localparam logic [2:0] S_REPORT   = 3'd4;

  // Stage timer counts down from TIMEOUT-1; terminal count is zero.
  localparam logic [TIMEOUT_W-1:0] TIMER_LOAD = TIMEOUT_W'(TIMEOUT - 1);

  logic [2:0]           state, state_nxt;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [WIDTH-1:0]     expected;
  logic [2:0]           stage_bit, later_bits;
  logic [2:0]           mask_q, mask_nxt;
  logic [TIMEOUT_W-1:0] timer_q, timer_nxt;
  logic                 tmo_nxt;
  logic                 finish;
  logic                 pass_nxt;

  always_comb begin
    state_nxt  = state;
    mask_nxt   = mask_q;
    timer_nxt  = timer_q;
    tmo_nxt    = 1'b0;
    expected   = '0;
    stage_bit  = 3'b000;
    later_bits = 3'b000;

    case (state)
      S_WAIT_OR: begin
        expected   = a_q | b_q;
        stage_bit  = 3'b001;
        later_bits = 3'b111;
      end
      S_WAIT_AND: begin
        expected   = a_q & b_q;
        stage_bit  = 3'b010;
        later_bits = 3'b110;
      end
      S_WAIT_XOR: begin
        expected   = a_q ^ b_q;
        stage_bit  = 3'b100;
        later_bits = 3'b100;
      end
      default: ;
    endcase

    case (state)
      S_IDLE: begin
        if (op_valid) begin
          state_nxt = S_WAIT_OR;
          mask_nxt  = 3'b000;
          timer_nxt = TIMER_LOAD;
        end
      end
      S_WAIT_OR, S_WAIT_AND, S_WAIT_XOR: begin
        // A result arriving on the terminal-count cycle is accepted, not timed out.
        if (res_valid) begin
          if (res_data != expected) mask_nxt = mask_q | stage_bit;
          timer_nxt = TIMER_LOAD;
          case (state)
            S_WAIT_OR:  state_nxt = S_WAIT_AND;
            S_WAIT_AND: state_nxt = S_WAIT_XOR;
            default:    state_nxt = S_REPORT;
          endcase
        end else if (timer_q == '0) begin
          tmo_nxt   = 1'b1;
          mask_nxt  = mask_q | later_bits;
          state_nxt = S_REPORT;
        end else begin
          timer_nxt = timer_q - 1'b1;
        end
      end
      S_REPORT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Verdict is registered on entry to REPORT so it is visible together with done.
  assign finish   = (state_nxt == S_REPORT) && (state != S_REPORT);
  assign pass_nxt = (mask_nxt == 3'b000) && !tmo_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mask_q    <= 3'b000;
      timer_q   <= '0;
      op_ready  <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_mask  <= 3'b000;
      timeout   <= 1'b0;
      err_count <= 8'd0;
      stray     <= 1'b0;
    end else begin
      state    <= state_nxt;
      mask_q   <= mask_nxt;
      timer_q  <= timer_nxt;
      op_ready <= (state_nxt == S_IDLE);
      done     <= finish;

      if (state == S_IDLE && op_valid) begin
        a_q <= op_a;
        b_q <= op_b;
      end

      if (finish) begin
        pass     <= pass_nxt;
        err_mask <= mask_nxt;
        timeout  <= tmo_nxt;
        if (!pass_nxt && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end

      if (res_valid && (state == S_IDLE || state == S_REPORT)) stray <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bitwise_result_checker.sv
// Directed-vector bench for bitwise_result_checker; expected values are hand-computed.
module tb_bitwise_result_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [7:0] op_a, op_b;
  logic       res_valid;
  logic [7:0] res_data;
  logic       done, pass, timeout, stray;
  logic [2:0] err_mask;
  logic [7:0] err_count;

  int checks   = 0;
  int failures = 0;

  bitwise_result_checker #(.WIDTH(8), .TIMEOUT(15), .TIMEOUT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .res_valid (res_valid),
    .res_data  (res_data),
    .done      (done),
    .pass      (pass),
    .err_mask  (err_mask),
    .timeout   (timeout),
    .err_count (err_count),
    .stray     (stray)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [7:0] a, input logic [7:0] b);
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    step();
    op_valid = 1'b0;
  endtask

  task automatic send_res(input logic [7:0] data, input int gap);
    res_valid = 1'b0;
    repeat (gap) step();
    res_valid = 1'b1;
    res_data  = data;
    step();
    res_valid = 1'b0;
  endtask

  initial begin
    int early_done;
    rst_n     = 1'b0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_valid = 1'b0;
    res_data  = '0;
    step();
    step();
    rst_n = 1'b1;

    check("rst_op_ready", op_ready, 1);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_mask", err_mask, 0);
    check("rst_timeout", timeout, 0);
    check("rst_err_count", err_count, 0);
    check("rst_stray", stray, 0);

    // Full-rate passing transaction: done visible right after XOR edge
    send_op(8'hA5, 8'h3C);
    check("t1_op_ready_busy", op_ready, 0);
    send_res(8'hBD, 0);
    send_res(8'h24, 0);
    check("t1_no_early_done", done, 0);
    send_res(8'h99, 0);
    check("t1_done", done, 1);
    check("t1_pass", pass, 1);
    check("t1_err_mask", err_mask, 3'b000);
    check("t1_err_count", err_count, 0);
    step();
    check("t1_done_pulse", done, 0);
    check("t1_op_ready_back", op_ready, 1);

    // Wrong AND stage with 3-cycle gaps; accepted on first IDLE cycle
    send_op(8'hA5, 8'h3C);
    check("t2_accepted", op_ready, 0);
    send_res(8'hBD, 3);
    send_res(8'h25, 3);
    send_res(8'h99, 3);
    check("t2_done", done, 1);
    check("t2_pass", pass, 0);
    check("t2_err_mask", err_mask, 3'b010);
    check("t2_timeout", timeout, 0);
    check("t2_err_count", err_count, 1);
    step();

    // Timeout in AND stage after 15 silent cycles
    send_op(8'hFF, 8'h00);
    send_res(8'hFF, 0);
    early_done = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (done) early_done++;
    end
    check("t3_no_early_done", early_done, 0);
    step();
    check("t3_done", done, 1);
    check("t3_timeout", timeout, 1);
    check("t3_err_mask", err_mask, 3'b110);
    check("t3_pass", pass, 0);
    check("t3_err_count", err_count, 2);
    step();

    // Result on the terminal-count cycle wins over the timeout
    send_op(8'h12, 8'h34);
    send_res(8'h36, 14);
    send_res(8'h10, 0);
    send_res(8'h26, 0);
    check("t4_done", done, 1);
    check("t4_pass", pass, 1);
    check("t4_timeout", timeout, 0);
    check("t4_err_count", err_count, 2);
    step();

    // Stray result in IDLE; sticky through a passing transaction
    res_valid = 1'b1;
    res_data  = 8'h55;
    step();
    res_valid = 1'b0;
    check("t5_stray", stray, 1);
    check("t5_no_done", done, 0);
    check("t5_op_ready", op_ready, 1);
    send_op(8'hA5, 8'h3C);
    send_res(8'hBD, 0);
    send_res(8'h24, 1);
    send_res(8'h99, 0);
    check("t5_done", done, 1);
    check("t5_pass", pass, 1);
    check("t5_stray_held", stray, 1);
    step();

    // Reset while in WAIT_AND aborts without a verdict
    send_op(8'hA5, 8'h3C);
    send_res(8'hBD, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t6_done", done, 0);
    check("t6_op_ready", op_ready, 1);
    check("t6_pass", pass, 0);
    check("t6_err_mask", err_mask, 0);
    check("t6_timeout", timeout, 0);
    check("t6_err_count", err_count, 0);
    check("t6_stray", stray, 0);
    step();
    check("t6_still_no_done", done, 0);
    send_op(8'h0F, 8'hF0);
    send_res(8'hFF, 0);
    send_res(8'h00, 0);
    send_res(8'hFF, 0);
    check("t6_post_done", done, 1);
    check("t6_post_pass", pass, 1);
    check("t6_post_err_mask", err_mask, 0);
    step();

    // 256 failing transactions: err_count saturates at 255
    for (int i = 0; i < 256; i++) begin
      send_op(8'h00, 8'h00);
      send_res(8'h01, 0);
      send_res(8'h00, 0);
      send_res(8'h00, 0);
      if (i == 0) check("t7_first_mask", err_mask, 3'b001);
      if (i == 253) check("t7_count_254", err_count, 254);
      if (i == 254) check("t7_count_255", err_count, 255);
      if (i == 255) begin
        check("t7_count_sat", err_count, 255);
        check("t7_done", done, 1);
        check("t7_pass", pass, 0);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
